// File: rtl/s2h_pkt_gate_pkg.sv
// s2h_pkt_gate_pkg
//   Shared definitions for the s2h store-and-forward packet gate:
//   write/read FSM state encodings, the CHDR length field position,
//   the drop counter width and a helper that converts a CHDR byte
//   length into the number of 64-bit words it occupies.
package s2h_pkt_gate_pkg;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_WRITE = 2'd1,
        WR_DROP  = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_FETCH  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

    localparam int CHDR_LEN_MSB = 47;
    localparam int CHDR_LEN_LSB = 32;
    localparam int DROP_CNT_W   = 16;

    // ceil(len / 8): number of 64-bit words carrying 'len' bytes.
    function automatic logic [16:0] chdr_len_words(input logic [15:0] len);
        logic [16:0] w_sum;
        w_sum = {1'b0, len} + 17'd7;
        return {3'b000, w_sum[16:3]};
    endfunction

endpackage

// File: rtl/s2h_pkt_gate_ram.sv
// pkt_gate_ram
//   Simple dual-port RAM, one write port and one read port on the same
//   clock, with a registered read (1-cycle latency). The read register
//   holds its value while i_rd_en is low. No reset on the array so it
//   maps onto block RAM.
// Ports:
//   i_clk                          clock
//   i_wr_en / i_wr_addr / i_wr_data write port
//   i_rd_en / i_rd_addr            read request
//   o_rd_data                      registered read data
module pkt_gate_ram #(
    parameter int AW = 10,
    parameter int DW = 65
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/s2h_pkt_gate.sv
// s2h_pkt_gate
//   Store-and-forward gate between the crossbar s2h output and the DMA
//   data mover. A packet is released only after its tlast word has been
//   written, so the output never stalls mid-packet. Packets too large
//   for the buffer are discarded and counted in drop_count.
//   Optional: define CHDR_LEN_CHECK_EN to also drop packets whose word
//   count disagrees with the CHDR header byte length (bits [47:32]).
// Ports:
//   bus_clk, bus_rst_n (async, active low), clear (sync flush)
//   i_tdata/i_tlast/i_tvalid/i_tready  input AXI-stream
//   o_tdata/o_tlast/o_tvalid/o_tready  output AXI-stream
//   occupied    words stored (committed + in-progress)
//   pkt_count   committed packets not yet fully read
//   drop_count  dropped packets, saturating
module s2h_pkt_gate
    import s2h_pkt_gate_pkg::*;
#(
    parameter int SIZE          = 10,
    parameter int MAX_PKTS_LOG2 = 5
) (
    input  logic                     bus_clk,
    input  logic                     bus_rst_n,
    input  logic                     clear,
    input  logic [63:0]              i_tdata,
    input  logic                     i_tlast,
    input  logic                     i_tvalid,
    output logic                     i_tready,
    output logic [63:0]              o_tdata,
    output logic                     o_tlast,
    output logic                     o_tvalid,
    input  logic                     o_tready,
    output logic [SIZE:0]            occupied,
    output logic [MAX_PKTS_LOG2:0]   pkt_count,
    output logic [DROP_CNT_W-1:0]    drop_count
);

    localparam int PC_W = MAX_PKTS_LOG2 + 1;
    localparam logic [SIZE-1:0]       PTR_ONE = 1;
    localparam logic [PC_W-1:0]       PC_ONE  = 1;
    localparam logic [DROP_CNT_W-1:0] DC_ONE  = 1;

    wr_state_t r_wr_state, w_wr_state_nxt;
    rd_state_t r_rd_state, w_rd_state_nxt;

    logic [SIZE-1:0]       r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic [PC_W-1:0]       r_pkt_count, w_pkt_nxt;
    logic [DROP_CNT_W-1:0] r_drop_count;
    logic                  r_in_rdy;

    logic                  w_full, w_len_ok;
    logic                  w_ready, w_mem_we, w_wr_adv, w_commit, w_rollback, w_drop_inc;
    logic                  w_rd_en, w_rd_adv, w_pkt_dec;
    logic [SIZE-1:0]       w_rd_addr, w_ptr_diff;
    logic [64:0]           w_rd_data;

    assign w_full     = ((r_wr_ptr + PTR_ONE) == r_rd_ptr);
    assign w_ptr_diff = r_wr_ptr - r_rd_ptr;

    // ---------------------------------------------------------------
    // Optional CHDR length check
    // ---------------------------------------------------------------
`ifdef CHDR_LEN_CHECK_EN
    logic [15:0] r_hdr_len, w_cur_len;
    logic [16:0] r_beat_cnt, w_cur_cnt;

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            r_hdr_len  <= '0;
            r_beat_cnt <= '0;
        end else if (w_mem_we) begin
            if (r_wr_state == WR_IDLE) begin
                r_hdr_len  <= i_tdata[CHDR_LEN_MSB:CHDR_LEN_LSB];
                r_beat_cnt <= 17'd1;
            end else begin
                r_beat_cnt <= r_beat_cnt + 17'd1;
            end
        end
    end

    // On the first beat the header is still on the bus, not in r_hdr_len.
    assign w_cur_len = (r_wr_state == WR_IDLE) ? i_tdata[CHDR_LEN_MSB:CHDR_LEN_LSB] : r_hdr_len;
    assign w_cur_cnt = (r_wr_state == WR_IDLE) ? 17'd1 : (r_beat_cnt + 17'd1);
    assign w_len_ok  = (chdr_len_words(w_cur_len) == w_cur_cnt);
`else
    assign w_len_ok = 1'b1;
`endif

    // ---------------------------------------------------------------
    // Write FSM
    // ---------------------------------------------------------------
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_ready        = 1'b0;
        w_mem_we       = 1'b0;
        w_wr_adv       = 1'b0;
        w_commit       = 1'b0;
        w_rollback     = 1'b0;
        w_drop_inc     = 1'b0;
        if (r_in_rdy && !clear) begin
            case (r_wr_state)
                WR_IDLE, WR_WRITE: begin
                    // Saturated pkt_count also stalls so it cannot wrap.
                    if ((w_full && (r_pkt_count != '0)) || (&r_pkt_count)) begin
                        w_ready = 1'b0;
                    end else if (w_full) begin
                        // Buffer holds only this packet: it can never fit.
                        w_ready    = 1'b1;
                        w_rollback = 1'b1;
                        if (i_tvalid && i_tlast) begin
                            w_drop_inc     = 1'b1;
                            w_wr_state_nxt = WR_IDLE;
                        end else begin
                            w_wr_state_nxt = WR_DROP;
                        end
                    end else begin
                        w_ready = 1'b1;
                        if (i_tvalid) begin
                            w_mem_we = 1'b1;
                            w_wr_adv = 1'b1;
                            if (i_tlast) begin
                                if (w_len_ok) begin
                                    w_commit = 1'b1;
                                end else begin
                                    w_rollback = 1'b1;
                                    w_drop_inc = 1'b1;
                                end
                                w_wr_state_nxt = WR_IDLE;
                            end else begin
                                w_wr_state_nxt = WR_WRITE;
                            end
                        end
                    end
                end
                WR_DROP: begin
                    w_ready = 1'b1;
                    if (i_tvalid && i_tlast) begin
                        w_drop_inc     = 1'b1;
                        w_wr_state_nxt = WR_IDLE;
                    end
                end
                default: w_wr_state_nxt = WR_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Read FSM
    // ---------------------------------------------------------------
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_en        = 1'b0;
        w_rd_addr      = r_rd_ptr;
        w_rd_adv       = 1'b0;
        w_pkt_dec      = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (r_pkt_count != '0) begin
                    w_rd_state_nxt = RD_FETCH;
                end
            end
            RD_FETCH: begin
                w_rd_en        = 1'b1;
                w_rd_state_nxt = RD_STREAM;
            end
            RD_STREAM: begin
                if (o_tready) begin
                    w_rd_adv = 1'b1;
                    if (w_rd_data[64]) begin
                        w_pkt_dec = 1'b1;
                        // Count after this decrement, including a commit this cycle.
                        w_rd_state_nxt = ((r_pkt_count > PC_ONE) || w_commit) ? RD_FETCH : RD_IDLE;
                    end else begin
                        // Prefetch the next word so the stream stays at 1 word/cycle.
                        w_rd_en   = 1'b1;
                        w_rd_addr = r_rd_ptr + PTR_ONE;
                    end
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        w_pkt_nxt = r_pkt_count;
        if (w_commit && !w_pkt_dec) begin
            w_pkt_nxt = r_pkt_count + PC_ONE;
        end else if (!w_commit && w_pkt_dec) begin
            w_pkt_nxt = r_pkt_count - PC_ONE;
        end
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            r_wr_state   <= WR_IDLE;
            r_rd_state   <= RD_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_pkt_count  <= '0;
            r_in_rdy     <= 1'b0;
        end else begin
            r_in_rdy <= 1'b1;
            if (clear) begin
                r_wr_state   <= WR_IDLE;
                r_rd_state   <= RD_IDLE;
                r_wr_ptr     <= '0;
                r_commit_ptr <= '0;
                r_rd_ptr     <= '0;
                r_pkt_count  <= '0;
            end else begin
                r_wr_state  <= w_wr_state_nxt;
                r_rd_state  <= w_rd_state_nxt;
                r_pkt_count <= w_pkt_nxt;
                if (w_rollback) begin
                    r_wr_ptr <= r_commit_ptr;
                end else if (w_wr_adv) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_commit) begin
                    r_commit_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_rd_adv) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
            end
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            r_drop_count <= '0;
        end else if (w_drop_inc && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + DC_ONE;
        end
    end

    pkt_gate_ram #(
        .AW (SIZE),
        .DW (65)
    ) u_ram (
        .i_clk     (bus_clk),
        .i_wr_en   (w_mem_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({i_tlast, i_tdata}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // The RAM read register is the output register; it is only valid in STREAM.
    assign o_tvalid   = (r_rd_state == RD_STREAM);
    assign o_tdata    = o_tvalid ? w_rd_data[63:0] : '0;
    assign o_tlast    = o_tvalid & w_rd_data[64];
    assign i_tready   = w_ready;
    assign occupied   = {1'b0, w_ptr_diff};
    assign pkt_count  = r_pkt_count;
    assign drop_count = r_drop_count;

endmodule
